// File: rtl/reg_bank_wr_if.sv
// ---------------------------------------------------------------------------
// reg_bank_wr_if
// Bundles the write-side handshake, the bulk-clear request and the flat
// register export of the 8-entry register bank.
//   master : requester side (drives wr_valid/wr_addr/wr_data/clr_req)
//   slave  : reg_bank_write_port side
// Signals:
//   wr_valid, wr_ready, wr_addr[2:0], wr_data[WIDTH-1:0]  write handshake
//   clr_req                                               level clear request
//   wr_onehot[7:0]                                        enable of committing write
//   wr_done, clr_done                                     1-cycle completion pulses
//   busy                                                  port not idle
//   q_flat[8*WIDTH-1:0]                                   register i at [i*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
interface reg_bank_wr_if #(
    parameter int WIDTH = 8
) ();
    logic                 wr_valid;
    logic                 wr_ready;
    logic [2:0]           wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic                 clr_req;
    logic [7:0]           wr_onehot;
    logic                 wr_done;
    logic                 clr_done;
    logic                 busy;
    logic [8*WIDTH-1:0]   q_flat;

    modport master (
        output wr_valid, wr_addr, wr_data, clr_req,
        input  wr_ready, wr_onehot, wr_done, clr_done, busy, q_flat
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, clr_req,
        output wr_ready, wr_onehot, wr_done, clr_done, busy, q_flat
    );
endinterface

// File: rtl/reg_bank_write_port.sv
// ---------------------------------------------------------------------------
// reg_bank_write_port
// Write side of the 8-entry register bank. Accepts one write per two cycles
// over valid/ready, decodes the address to a one-hot enable, and provides a
// bulk clear that sweeps all 8 entries with a counter. Register contents are
// exported flat (purely registered) for the read mux tree.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        reg_bank_wr_if.slave (handshake, clear, pulses, q_flat)
//   wr_protect [7:0] per-address write protect  (REG_BANK_WR_PROTECT_EN only)
//   wr_err     1-cycle pulse: commit blocked     (REG_BANK_WR_PROTECT_EN only)
//
// Parameters:
//   WIDTH      bits per register
//   ZERO_REG0  1: entry 0 reads 0; writes to it complete but store nothing
//
// Optional feature macro: REG_BANK_WR_PROTECT_EN
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | ready for a write unless a clear is requested
// COMMIT | latched write lands in the bank at the end of this cycle
// CLEAR  | zeroing reg[sweep_cnt], one entry per cycle, 8 cycles
// ---------------------------------------------------------------------------
module reg_bank_write_port #(
    parameter int WIDTH     = 8,
    parameter bit ZERO_REG0 = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
`ifdef REG_BANK_WR_PROTECT_EN
    input  logic [7:0] wr_protect,
    output logic       wr_err,
`endif
    reg_bank_wr_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        CLEAR  = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       addr_q;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       sweep_cnt;
    logic [WIDTH-1:0] regs [8];
    logic             wr_done_q;
    logic             clr_done_q;
    logic             commit_ok;

`ifdef REG_BANK_WR_PROTECT_EN
    logic             wr_err_q;
    assign commit_ok = ~wr_protect[addr_q];
    assign wr_err    = wr_err_q;
`else
    assign commit_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            sweep_cnt  <= '0;
            wr_done_q  <= 1'b0;
            clr_done_q <= 1'b0;
`ifdef REG_BANK_WR_PROTECT_EN
            wr_err_q   <= 1'b0;
`endif
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_done_q  <= 1'b0;
            clr_done_q <= 1'b0;
`ifdef REG_BANK_WR_PROTECT_EN
            wr_err_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // Clear wins: wr_ready is low whenever clr_req is high.
                    if (bus.clr_req) begin
                        state     <= CLEAR;
                        sweep_cnt <= '0;
                    end else if (bus.wr_valid) begin
                        addr_q <= bus.wr_addr;
                        data_q <= bus.wr_data;
                        state  <= COMMIT;
                    end
                end
                COMMIT: begin
                    if (commit_ok) begin
                        if (!(ZERO_REG0 && addr_q == 3'd0)) begin
                            regs[addr_q] <= data_q;
                        end
                        wr_done_q <= 1'b1;
                    end else begin
`ifdef REG_BANK_WR_PROTECT_EN
                        wr_err_q <= 1'b1;
`endif
                    end
                    // A clear raised during the commit is honoured right after it,
                    // so a single-cycle clr_req here is not lost.
                    sweep_cnt <= '0;
                    state     <= bus.clr_req ? CLEAR : IDLE;
                end
                CLEAR: begin
                    regs[sweep_cnt] <= '0;
                    sweep_cnt       <= sweep_cnt + 3'd1;
                    if (sweep_cnt == 3'd7) begin
                        state      <= IDLE;
                        clr_done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.wr_onehot = 8'h00;
        case (state)
            COMMIT:  if (commit_ok) bus.wr_onehot = 8'h01 << addr_q;
            CLEAR:   bus.wr_onehot = 8'h01 << sweep_cnt;
            default: bus.wr_onehot = 8'h00;
        endcase
    end

    // rst_n is folded in so the port never advertises ready while held in reset.
    assign bus.wr_ready = rst_n & (state == IDLE) & ~bus.clr_req;
    assign bus.busy     = (state != IDLE);
    assign bus.wr_done  = wr_done_q;
    assign bus.clr_done = clr_done_q;

    for (genvar g = 0; g < 8; g++) begin : g_q
        if (ZERO_REG0 && g == 0) begin : g_zero
            assign bus.q_flat[g*WIDTH +: WIDTH] = '0;
        end else begin : g_reg
            assign bus.q_flat[g*WIDTH +: WIDTH] = regs[g];
        end
    end

endmodule
